uart_dma_fifo: RTL and testbench
================================

Name: uart_dma_fifo

Overview:
Parametrised successor to the fixed 13-entry UART byte buffers: a memory-mapped RX and TX circular FIFO pair with configurable depth.
- Adds full/empty tracking, sticky overflow flags, a status/level register and a threshold interrupt.
- Sits between the core's data bus (addr/src/mem_write/mem_read/byte_enable/read_data) and the existing uart_rx/uart_tx bit engines.
- Single clock domain; the bit engines deliver and accept bytes on clk.

Parameters:
BASE_ADDR, 32'h0100_0000, bus base address; block decodes addr[31:4]==BASE_ADDR[31:4]
DEPTH, 16, entries per FIFO; power of two, 2..256
DATA_W, 8, bits per FIFO entry (1..8)
CNT_W, $clog2(DEPTH)+1, level counter width (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
addr  in  32  bus byte address
src  in  32  bus write data
mem_write  in  1  bus write strobe, one cycle per access
mem_read  in  1  bus read strobe, one cycle per access
byte_enable  in  4  write byte lanes; lane 0 must be set for DATA/CTRL/STATUS writes to take effect
read_data  out  32  combinational read data, 0 when not selected
rx_valid  in  1  uart_rx byteReady strobe
rx_data  in  DATA_W  received byte
tx_valid  out  1  TX FIFO not empty
tx_data  out  DATA_W  TX FIFO head
tx_ready  in  1  serializer accepts head this cycle
irq  out  1  interrupt request, registered

Behaviour:
Register map (offset = addr[3:2]):
- 0 DATA. Read returns the RX head in [DATA_W-1:0] and pops it. Write pushes src[DATA_W-1:0] into TX.
- 1 STATUS, bits:
  - [0] rx_empty
  - [1] rx_full
  - [2] tx_empty
  - [3] tx_full
  - [4] rx_overflow (sticky)
  - [5] tx_overflow (sticky)
  - [6] irq
  - Writing 1 to bit 4 or 5 clears that flag.
- 2 CTRL, read/write:
  - [0] irq_en
  - [15:8] rx_threshold
- 3 LEVEL, read-only: [CNT_W-1:0] rx_count, [CNT_W+15:16] tx_count.
- Unused bits read 0.

Read and pop timing:
- read_data is combinational from the current state.
- The pop takes effect at the same clk edge that samples mem_read.
- Zero-latency read; the next read sees the next entry.

FIFO implementation:
- Each FIFO uses rd_ptr/wr_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, plus a count of CNT_W bits.
- full = (count==DEPTH); empty = (count==0).

RX rules:
- rx_valid while not full: store the byte and increment count.
- rx_valid while full and no pop this cycle: drop the byte and set rx_overflow.
- rx_valid while full with a same-cycle DATA read: accept the byte; count unchanged.
- DATA read while empty: returns 0; no pointer or count change; no flag.
- Simultaneous push and pop while empty: the read returns 0 and the push is accepted (count becomes 1).

TX rules:
- tx_valid = !tx_empty; tx_data = head.
- Pop on tx_valid && tx_ready.
- Bus DATA write while full and no same-cycle pop: dropped; set tx_overflow.
- Bus DATA write while full with a same-cycle pop: accepted.

irq:
- irq <= irq_en && ((rx_count >= rx_threshold && rx_threshold != 0) || rx_overflow).
- Latency is one cycle after the causing condition.

Reset:
- Pointers, counts, flags and CTRL are cleared.
- Outputs: read_data=0 when unselected, tx_valid=0, tx_data=0, irq=0.
- Reset takes priority over any same-cycle access.
- A reset in mid-transfer discards all queued bytes.

Ignored accesses:
- Access with an unmatched address, or with mem_write and mem_read both high, is ignored: no state change, read_data=0.

Decomposition:
Package uart_dma_pkg holds:
- register offsets: REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2, REG_LEVEL=2'd3
- STATUS bit indices
- CTRL field positions

Sub-module sync_fifo (DEPTH, DATA_W):
- ports: push, pop, din, dout, count, full, empty
- implements the full/pop-same-cycle rule
- instantiated twice, once for RX and once for TX
- storage uses distributed RAM.

Test Plan:
1. After reset: STATUS reads 32'h0000_0005, LEVEL reads 0, tx_valid=0, irq=0.
2. With DEPTH=16, push RX bytes 0x41..0x50 (16 bytes) → rx_full=1. A 17th byte 0x51 sets rx_overflow. Sixteen DATA reads return 0x41..0x50 in order. A 17th read returns 0 and rx_empty=1.
3. Bus-write 0x55, then 0xAA, with tx_ready=0 → tx_valid=1, tx_data=0x55, LEVEL tx_count=2. Pulse tx_ready for one cycle → tx_data=0xAA next cycle.
4. Wrap-around: 40 interleaved push/pop pairs through RX → data order preserved across pointer wrap; final rx_count=0.
5. Full boundary: with RX full, assert rx_valid=0x77 and a DATA read in the same cycle → read returns the oldest byte, count stays 16, rx_overflow stays 0, and 0x77 is read last.
6. Set CTRL=32'h0000_0401 (threshold 4, irq_en=1) → irq rises one cycle after the 4th RX byte. Four DATA reads drop rx_count to 0 → irq falls. Overflow then keeps irq high until STATUS bit 4 is written with 1.

Source files
------------

// File: rtl/uart_dma_pkg.sv
// Shared register map definitions for the UART RX/TX FIFO block.
package uart_dma_pkg;

    // Register offsets, selected by addr[3:2]
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_LEVEL  = 2'd3
    } reg_off_e;

    // STATUS bit indices
    localparam int unsigned ST_RX_EMPTY = 0;
    localparam int unsigned ST_RX_FULL  = 1;
    localparam int unsigned ST_TX_EMPTY = 2;
    localparam int unsigned ST_TX_FULL  = 3;
    localparam int unsigned ST_RX_OVF   = 4;
    localparam int unsigned ST_TX_OVF   = 5;
    localparam int unsigned ST_IRQ      = 6;

    // CTRL field positions
    localparam int unsigned CTRL_IRQ_EN  = 0;
    localparam int unsigned CTRL_THR_LSB = 8;
    localparam int unsigned CTRL_THR_MSB = 15;

    // LEVEL field base for tx_count
    localparam int unsigned LEVEL_TX_LSB = 16;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with a level counter; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_eff;
    logic              push_eff;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Effective push/pop and next pointer/count values
    always_comb begin
        pop_eff  = pop && !empty;
        push_eff = push && (!full || pop_eff);
        rd_ptr_d = pop_eff  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push_eff ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and level registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (push_eff && !reset) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_dma_fifo.sv
// Memory-mapped RX/TX byte FIFO pair between the core bus and the UART bit engines.
module uart_dma_fifo
    import uart_dma_pkg::*;
#(
    parameter  logic [31:0] BASE_ADDR = 32'h0100_0000,
    parameter  int unsigned DEPTH     = 16,
    parameter  int unsigned DATA_W    = 8,
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [31:0]       src,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [3:0]        byte_enable,
    output logic [31:0]       read_data,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              irq
);

    logic              sel;
    logic              bus_rd;
    logic              bus_wr;
    reg_off_e          off;
    logic              rx_pop_req;
    logic              tx_push_req;
    logic              tx_pop_req;
    logic              status_wr;
    logic              ctrl_wr;

    logic [DATA_W-1:0] rx_dout;
    logic [DATA_W-1:0] tx_dout;
    logic [CNT_W-1:0]  rx_count;
    logic [CNT_W-1:0]  tx_count;
    logic              rx_full, rx_empty;
    logic              tx_full, tx_empty;

    logic              rx_ovf_q, rx_ovf_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic              irq_en_q, irq_en_d;
    logic [7:0]        rx_thr_q, rx_thr_d;
    logic              irq_q, irq_d;

    logic              unused_bits;

    assign unused_bits = ^{addr[1:0], src, byte_enable};

    // Bus decode; an access with both strobes high is ignored entirely
    always_comb begin
        sel         = (addr[31:4] == BASE_ADDR[31:4]) && (mem_write ^ mem_read);
        bus_rd      = sel && mem_read;
        bus_wr      = sel && mem_write;
        off         = reg_off_e'(addr[3:2]);
        rx_pop_req  = bus_rd && (off == REG_DATA);
        tx_push_req = bus_wr && (off == REG_DATA) && byte_enable[0];
        status_wr   = bus_wr && (off == REG_STATUS) && byte_enable[0];
        ctrl_wr     = bus_wr && (off == REG_CTRL) && byte_enable[0];
        tx_pop_req  = !tx_empty && tx_ready;
    end

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_valid),
        .pop   (rx_pop_req),
        .din   (rx_data),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push_req),
        .pop   (tx_pop_req),
        .din   (src[DATA_W-1:0]),
        .dout  (tx_dout),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? '0 : tx_dout;
    assign irq      = irq_q;

    // Next-state for sticky flags, CTRL and the interrupt; a same-cycle set beats a clear
    always_comb begin
        rx_ovf_d = rx_ovf_q;
        tx_ovf_d = tx_ovf_q;
        irq_en_d = irq_en_q;
        rx_thr_d = rx_thr_q;
        if (status_wr && src[ST_RX_OVF]) rx_ovf_d = 1'b0;
        if (status_wr && src[ST_TX_OVF]) tx_ovf_d = 1'b0;
        if (rx_valid && rx_full && !rx_pop_req) rx_ovf_d = 1'b1;
        if (tx_push_req && tx_full && !tx_pop_req) tx_ovf_d = 1'b1;
        if (ctrl_wr) begin
            irq_en_d = src[CTRL_IRQ_EN];
            rx_thr_d = src[CTRL_THR_MSB:CTRL_THR_LSB];
        end
        irq_d = irq_en_q &&
                (((9'(rx_count) >= 9'(rx_thr_q)) && (rx_thr_q != '0)) || rx_ovf_q);
    end

    // Control/status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            irq_en_q <= 1'b0;
            rx_thr_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            rx_ovf_q <= rx_ovf_d;
            tx_ovf_q <= tx_ovf_d;
            irq_en_q <= irq_en_d;
            rx_thr_q <= rx_thr_d;
            irq_q    <= irq_d;
        end
    end

    // Combinational read mux; zero unless a valid read selects this block
    always_comb begin
        read_data = '0;
        if (bus_rd) begin
            case (off)
                REG_DATA: begin
                    read_data[DATA_W-1:0] = rx_empty ? '0 : rx_dout;
                end
                REG_STATUS: begin
                    read_data[ST_RX_EMPTY] = rx_empty;
                    read_data[ST_RX_FULL]  = rx_full;
                    read_data[ST_TX_EMPTY] = tx_empty;
                    read_data[ST_TX_FULL]  = tx_full;
                    read_data[ST_RX_OVF]   = rx_ovf_q;
                    read_data[ST_TX_OVF]   = tx_ovf_q;
                    read_data[ST_IRQ]      = irq_q;
                end
                REG_CTRL: begin
                    read_data[CTRL_IRQ_EN]               = irq_en_q;
                    read_data[CTRL_THR_MSB:CTRL_THR_LSB] = rx_thr_q;
                end
                REG_LEVEL: begin
                    read_data[CNT_W-1:0]                         = rx_count;
                    read_data[LEVEL_TX_LSB+CNT_W-1:LEVEL_TX_LSB] = tx_count;
                end
                default: read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_dma_fifo.sv
// Self-checking bench for uart_dma_fifo: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_uart_dma_fifo;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 16;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] src;
    logic        mem_write;
    logic        mem_read;
    logic [3:0]  byte_enable;
    logic [31:0] read_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        irq;

    int errors = 0;
    int checks = 0;

    // Observed values (sampled mid-cycle) and model expectations for the same instant
    logic [31:0] o_rd, e_rd;
    logic        o_txv, e_txv;
    logic [7:0]  o_txd, e_txd;
    logic        o_irq, e_irq;

    // Reference model state
    logic [7:0] mrx[$];
    logic [7:0] mtx[$];
    bit         m_rxovf, m_txovf, m_irqen, m_irq;
    logic [7:0] m_thr;

    uart_dma_fifo #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .DATA_W    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .src         (src),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .byte_enable (byte_enable),
        .read_data   (read_data),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    function automatic bit bus_sel();
        return (addr[31:4] == BASE[31:4]) && (mem_write ^ mem_read);
    endfunction

    // Model outputs for the current cycle, before the clock edge
    task automatic model_expect();
        int rxn = mrx.size();
        int txn = mtx.size();
        e_rd = '0;
        if (bus_sel() && mem_read) begin
            case (addr[3:2])
                2'd0: e_rd = (rxn > 0) ? {24'h0, mrx[0]} : 32'h0;
                2'd1: e_rd = {25'h0, m_irq, m_txovf, m_rxovf, txn == DEPTH, txn == 0,
                              rxn == DEPTH, rxn == 0};
                2'd2: e_rd = {16'h0, m_thr, 7'h0, m_irqen};
                default: e_rd = (txn << 16) | rxn;
            endcase
        end
        e_txv = (txn > 0);
        e_txd = (txn > 0) ? mtx[0] : 8'h00;
        e_irq = m_irq;
    endtask

    // Model state update at the clock edge
    task automatic model_step();
        bit sel;
        bit irq_n;
        if (reset) begin
            mrx.delete(); mtx.delete();
            m_rxovf = 0; m_txovf = 0; m_irqen = 0; m_irq = 0; m_thr = 0;
            return;
        end
        irq_n = m_irqen && (((mrx.size() >= int'(m_thr)) && m_thr != 0) || m_rxovf);
        sel = bus_sel();
        if (sel && mem_write && addr[3:2] == 2'd1 && byte_enable[0]) begin
            if (src[4]) m_rxovf = 0;
            if (src[5]) m_txovf = 0;
        end
        if (sel && mem_write && addr[3:2] == 2'd2 && byte_enable[0]) begin
            m_irqen = src[0];
            m_thr   = src[15:8];
        end
        if (sel && mem_read && addr[3:2] == 2'd0 && mrx.size() > 0) void'(mrx.pop_front());
        if (rx_valid) begin
            if (mrx.size() < DEPTH) mrx.push_back(rx_data);
            else m_rxovf = 1;
        end
        if (tx_ready && mtx.size() > 0) void'(mtx.pop_front());
        if (sel && mem_write && addr[3:2] == 2'd0 && byte_enable[0]) begin
            if (mtx.size() < DEPTH) mtx.push_back(src[7:0]);
            else m_txovf = 1;
        end
        m_irq = irq_n;
    endtask

    // One clock cycle: drive, sample at the falling edge, advance model at the rising edge
    task automatic cycle(input bit rst, input bit rxv, input logic [7:0] rxd,
                         input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input bit txr);
        reset = rst; rx_valid = rxv; rx_data = rxd; mem_write = w; mem_read = r;
        addr = a; src = wd; byte_enable = be; tx_ready = txr;
        @(negedge clk);
        o_rd = read_data; o_txv = tx_valid; o_txd = tx_data; o_irq = irq;
        model_expect();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 8'h00, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    endtask

    task automatic rx_push(input logic [7:0] b);
        cycle(0, 1, b, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    endtask

    task automatic rd_reg(input int off);
        cycle(0, 0, 8'h00, 0, 1, BASE + 32'(off * 4), 32'h0, 4'h0, 0);
    endtask

    task automatic wr_reg(input int off, input logic [31:0] d);
        cycle(0, 0, 8'h00, 1, 0, BASE + 32'(off * 4), d, 4'hF, 0);
    endtask

    task automatic test_reset();
        // Accesses during reset must be overridden
        cycle(1, 1, 8'h99, 1, 0, BASE, 32'h33, 4'hF, 0);
        cycle(1, 1, 8'h98, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        rd_reg(1);
        checks++; if (o_rd !== 32'h5) begin errors++; $display("FAIL reset_status: got %h want %h", o_rd, 32'h5); end
        checks++; if (o_txv !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", o_txv); end
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", o_irq); end
        rd_reg(3);
        checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL reset_level: got %h want 0", o_rd); end
    endtask

    task automatic test_rx_fill();
        for (int i = 0; i < 16; i++) rx_push(8'(8'h41 + i));
        rd_reg(1);
        checks++; if (o_rd !== 32'h6) begin errors++; $display("FAIL rx_full_status: got %h want %h", o_rd, 32'h6); end
        rx_push(8'h51);
        rd_reg(1);
        checks++; if (o_rd !== 32'h16) begin errors++; $display("FAIL rx_ovf_status: got %h want %h", o_rd, 32'h16); end
        for (int i = 0; i < 16; i++) begin
            rd_reg(0);
            checks++;
            if (o_rd !== 32'(8'h41 + i)) begin errors++; $display("FAIL rx_read[%0d]: got %h want %h", i, o_rd, 32'(8'h41 + i)); end
        end
        rd_reg(0);
        checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL rx_read_empty: got %h want 0", o_rd); end
        rd_reg(1);
        checks++; if (o_rd !== 32'h15) begin errors++; $display("FAIL rx_empty_status: got %h want %h", o_rd, 32'h15); end
        wr_reg(1, 32'h10);
        rd_reg(1);
        checks++; if (o_rd !== 32'h5) begin errors++; $display("FAIL rx_ovf_clear: got %h want %h", o_rd, 32'h5); end
    endtask

    task automatic test_tx();
        wr_reg(0, 32'h55);
        wr_reg(0, 32'hAA);
        idle();
        checks++; if (o_txv !== 1'b1) begin errors++; $display("FAIL tx_valid: got %b want 1", o_txv); end
        checks++; if (o_txd !== 8'h55) begin errors++; $display("FAIL tx_head: got %h want 55", o_txd); end
        rd_reg(3);
        checks++; if (o_rd !== 32'h0002_0000) begin errors++; $display("FAIL tx_level: got %h want %h", o_rd, 32'h0002_0000); end
        cycle(0, 0, 8'h00, 0, 0, 32'h0, 32'h0, 4'h0, 1);
        idle();
        checks++; if (o_txd !== 8'hAA) begin errors++; $display("FAIL tx_next: got %h want AA", o_txd); end
        cycle(0, 0, 8'h00, 0, 0, 32'h0, 32'h0, 4'h0, 1);
        idle();
        checks++; if (o_txv !== 1'b0 || o_txd !== 8'h00) begin errors++; $display("FAIL tx_drained: got v=%b d=%h want v=0 d=00", o_txv, o_txd); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) rx_push(8'(8'h80 + i));
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 8'(8'h83 + i), 0, 1, BASE, 32'h0, 4'h0, 0);
            checks++;
            if (o_rd !== 32'(8'h80 + i)) begin errors++; $display("FAIL wrap_read[%0d]: got %h want %h", i, o_rd, 32'(8'h80 + i)); end
        end
        for (int i = 40; i < 43; i++) begin
            rd_reg(0);
            checks++;
            if (o_rd !== 32'(8'h80 + i)) begin errors++; $display("FAIL wrap_drain[%0d]: got %h want %h", i, o_rd, 32'(8'h80 + i)); end
        end
        rd_reg(3);
        checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL wrap_level: got %h want 0", o_rd); end
    endtask

    task automatic test_full_boundary();
        for (int i = 0; i < 16; i++) rx_push(8'(8'h60 + i));
        cycle(0, 1, 8'h77, 0, 1, BASE, 32'h0, 4'h0, 0);
        checks++; if (o_rd !== 32'h60) begin errors++; $display("FAIL full_pop_push_read: got %h want 60", o_rd); end
        rd_reg(3);
        checks++; if (o_rd !== 32'd16) begin errors++; $display("FAIL full_pop_push_level: got %h want %h", o_rd, 32'd16); end
        rd_reg(1);
        checks++; if (o_rd !== 32'h6) begin errors++; $display("FAIL full_pop_push_status: got %h want %h", o_rd, 32'h6); end
        for (int i = 1; i < 16; i++) begin
            rd_reg(0);
            checks++;
            if (o_rd !== 32'(8'h60 + i)) begin errors++; $display("FAIL full_drain[%0d]: got %h want %h", i, o_rd, 32'(8'h60 + i)); end
        end
        rd_reg(0);
        checks++; if (o_rd !== 32'h77) begin errors++; $display("FAIL full_last: got %h want 77", o_rd); end
    endtask

    task automatic test_irq();
        wr_reg(2, 32'h0000_0401);
        rd_reg(2);
        checks++; if (o_rd !== 32'h401) begin errors++; $display("FAIL ctrl_readback: got %h want %h", o_rd, 32'h401); end
        for (int i = 0; i < 4; i++) rx_push(8'(8'hB0 + i));
        idle();
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b want 0", o_irq); end
        idle();
        checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", o_irq); end
        for (int i = 0; i < 4; i++) rd_reg(0);
        idle();
        idle();
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", o_irq); end
        for (int i = 0; i < 17; i++) rx_push(8'(8'hC0 + i));
        for (int i = 0; i < 16; i++) rd_reg(0);
        idle();
        idle();
        checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL irq_ovf_hold: got %b want 1", o_irq); end
        wr_reg(1, 32'h10);
        idle();
        idle();
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL irq_ovf_clear: got %b want 0", o_irq); end
        wr_reg(2, 32'h0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bit          rst = ($urandom_range(0, 99) == 0);
            bit          rxv = ($urandom_range(0, 2) == 0);
            logic [7:0]  rxd = 8'($urandom);
            bit          txr = ($urandom_range(0, 3) == 0);
            bit          w = 0, r = 0;
            logic [31:0] a = BASE;
            logic [31:0] wd = 32'($urandom);
            logic [3:0]  be = 4'hF;
            case ($urandom_range(0, 9))
                0, 1: begin r = 1; a = BASE; end
                2:    begin r = 1; a = BASE + 32'd4; end
                3:    begin r = 1; a = BASE + 32'd12; end
                4:    begin r = 1; a = BASE + 32'd8; end
                5, 6: begin w = 1; a = BASE; be = 4'($urandom); end
                7:    begin w = 1; a = BASE + 32'd4; wd = 32'($urandom_range(0, 1) << 4) | 32'($urandom_range(0, 1) << 5); end
                8:    begin w = 1; a = BASE + 32'd8; wd = 32'($urandom_range(0, 18) << 8) | 32'($urandom_range(0, 1)); end
                default: begin
                    if ($urandom_range(0, 1) == 0) begin r = 1; a = BASE ^ 32'h0000_0100; end
                    else begin r = 1; w = 1; a = BASE; end
                end
            endcase
            cycle(rst, rxv, rxd, w, r, a, wd, be, txr);
            checks++; if (o_rd !== e_rd) begin errors++; $display("FAIL rand_read_data[%0d]: got %h want %h", n, o_rd, e_rd); end
            checks++; if (o_txv !== e_txv) begin errors++; $display("FAIL rand_tx_valid[%0d]: got %b want %b", n, o_txv, e_txv); end
            checks++; if (o_txd !== e_txd) begin errors++; $display("FAIL rand_tx_data[%0d]: got %h want %h", n, o_txd, e_txd); end
            checks++; if (o_irq !== e_irq) begin errors++; $display("FAIL rand_irq[%0d]: got %b want %b", n, o_irq, e_irq); end
        end
    endtask

    initial begin
        reset = 1'b1; addr = '0; src = '0; mem_write = 0; mem_read = 0;
        byte_enable = '0; rx_valid = 0; rx_data = '0; tx_ready = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_rx_fill();
        test_tx();
        test_wrap();
        test_full_boundary();
        test_irq();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
